// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, one full-subtractor cell.
// Latency WIDTH+1 cycles from accepted start to done; start is accepted only while ready (IDLE/DONE).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] sr;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             a_sign;
   logic             b_sign;

   logic             x;
   logic             y;
   logic             diff;
   logic             br_next;
   logic             last;
   logic [WIDTH-1:0] res;

   // Full-subtractor cell: difference and borrow-out of x - y - br.
   assign x       = sa[0];
   assign y       = sb[0];
   assign diff    = x ^ y ^ br;
   assign br_next = (~x & y) | (~(x ^ y) & br);

   // sr holds the WIDTH-1 bits already produced; res is the result including this cycle's bit.
   assign res  = {diff, sr};
   assign last = (cnt == CW'(WIDTH - 1));

   assign ready = (state == IDLE) || (state == DONE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         a_sign <= 1'b0;
         b_sign <= 1'b0;
         d      <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  br     <= 1'b0;
                  cnt    <= '0;
                  a_sign <= a[WIDTH-1];
                  b_sign <= b[WIDTH-1];
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= res[WIDTH-1:1];
               br  <= br_next;
               cnt <= cnt + CW'(1);
               if (last) begin
                  state <= DONE;
                  d     <= res;
                  bout  <= br_next;
                  ovf   <= (a_sign != b_sign) && (res[WIDTH-1] != a_sign);
                  zero  <= (res == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial two's-complement subtractor: computes d = a − b, one bit per clock, LSB first.
- Uses a single full-subtractor cell (difference plus borrow), the dual of the combinational full_adder cell.
- Operands are accepted through a start/ready handshake. The block reports the result, final borrow, signed overflow and zero flags with a one-cycle done pulse.
- Used as the area-minimal subtract path next to the adder cells in the arithmetic datapath.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- ready  output  1  high in IDLE and DONE; start is accepted only while high
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward
- d  output  WIDTH  difference a − b, modulo 2^WIDTH
- bout  output  1  final borrow; 1 when unsigned a < b
- ovf  output  1  signed overflow of a − b
- zero  output  1  1 when d == 0

## Operation
- **States:**
  - IDLE: ready=1.
  - RUN: busy=1, runs WIDTH cycles.
  - DONE: done=1, ready=1, lasts exactly one cycle.
- **Transitions:**
  - IDLE→RUN on start.
  - RUN→DONE when the bit counter reaches WIDTH−1.
  - DONE→RUN on start (back-to-back operation).
  - DONE→IDLE otherwise.
- **Accept:**
  - On an accepted start, load the shift registers sa←a and sb←b.
  - Clear the internal borrow (br←0) and the bit counter (cnt←0).
  - Latch sign bits a[WIDTH−1] and b[WIDTH−1] for the overflow computation.
- **Per RUN cycle:**
  - x=sa[0], y=sb[0].
  - diff = x ^ y ^ br.
  - br_next = (~x & y) | (~(x ^ y) & br).
  - Shift sa and sb right by one.
  - Shift diff into the MSB of the internal result register sr; sr shifts right.
  - cnt increments.
- **On the RUN→DONE edge**, load the output registers:
  - d ← final sr, including the last diff bit.
  - bout ← br_next.
  - ovf ← (a_sign != b_sign) && (d[WIDTH−1] != a_sign).
  - zero ← (d == 0).
- **Output holding:**
  - d, bout, ovf and zero hold their values until the next RUN→DONE edge.
  - They do not change during RUN.
- **Ignored inputs:** start during RUN is ignored. a and b are ignored except on an accepted start.
- **Width:**
  - cnt is ceil(log2(WIDTH)) bits.
  - Arithmetic wraps modulo 2^WIDTH.
  - No sign extension.

## Timing
- **Reset:**
  - State→IDLE.
  - ready=1, busy=0, done=0, d=0, bout=0, ovf=0, zero=0.
  - Internal registers are cleared.
- **Latency:**
  - start sampled high at edge E0.
  - busy is high for cycles E0..E(WIDTH−1).
  - done is high for the single cycle following edge E(WIDTH).
  - Outputs d, bout, ovf and zero are valid from that same cycle.
- **Throughput:** one operation per WIDTH+1 cycles when start is held high continuously. start in the DONE cycle is accepted with no IDLE gap.
- **Reset mid-RUN:**
  - The operation is aborted and all outputs go to their reset values.
  - done never pulses for the aborted operation.
  - ready=1 in the cycle after reset deasserts.
- **reset together with start:** reset wins; the operation is not accepted.
- **ready and busy** are decoded directly from the state register, with no combinational path from start.

## Test plan
- WIDTH=8, a=100, b=37, start one cycle:
  - Required: busy high 8 cycles, done pulses on the 9th cycle after the start edge.
  - Required: d=63, bout=0, ovf=0, zero=0.
- a=0x00, b=0x01:
  - Required: d=0xFF, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01:
  - Required: d=0x7F, bout=0, ovf=1 (−128−1 overflows), zero=0.
- a=0x55, b=0x55, then start held high with new operands a=0x10, b=0x20 presented in the DONE cycle:
  - Required first result: d=0x00, zero=1, bout=0.
  - Required: second operation accepted immediately, giving d=0xF0, bout=1, ovf=0.
  - Required: start pulses during RUN are ignored.
- Reset at the 4th RUN cycle of a=0x3C, b=0x0F:
  - Required: no done pulse, all outputs 0, ready=1 afterwards.
  - Required: a following start with a=0x3C, b=0x0F gives d=0x2D.
- Randomized 1000 operand pairs against the reference model a−b at WIDTH=8 and WIDTH=16:
  - Required: d, bout, ovf and zero all match the model.
